// File: rtl/kmerge_mul_pkg.sv
// Shared constants for the kmerge signed x unsigned multiply pipeline:
// saturation-mode encodings and the legal pipeline depth limits.
package kmerge_mul_pkg;

   // Result handling when the full product does not fit in P_W bits.
   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } sat_mode_e;

   localparam int SAT_MODE_WRAP = 0;
   localparam int SAT_MODE_SAT  = 1;

   // Pipeline depth limits (input-to-output latency in cycles).
   localparam int NUM_STAGE_MIN = 2;
   localparam int NUM_STAGE_MAX = 8;

endpackage

// File: rtl/kmerge_mul_sat.sv
// Range check, clamp and overflow flag for the full-width product.
// Purely combinational; sits in front of the output register.
module kmerge_mul_sat
   import kmerge_mul_pkg::*;
#(
   parameter int FULL_W   = 36,
   parameter int P_W      = 18,
   parameter int SAT_MODE = SAT_MODE_WRAP
) (
   input  logic signed [FULL_W-1:0] prod_i,
   output logic signed [P_W-1:0]    dout_o,
   output logic                     ovf_o
);

   // The product fits in signed P_W when every bit from P_W-1 upward is a
   // copy of the sign bit.
   localparam int HI_W = FULL_W - P_W + 1;

   logic [HI_W-1:0] hi_s;
   logic            fits_s;

   assign hi_s   = prod_i[FULL_W-1:P_W-1];
   assign fits_s = (&hi_s) | ~(|hi_s);

   // Keep the low bits when in range or wrapping; otherwise clamp by sign.
   always_comb begin
      ovf_o = ~fits_s;
      if (fits_s || (SAT_MODE != SAT_MODE_SAT)) begin
         dout_o = prod_i[P_W-1:0];
      end else if (prod_i[FULL_W-1]) begin
         dout_o = {1'b1, {(P_W-1){1'b0}}};
      end else begin
         dout_o = {1'b0, {(P_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/kmerge_mul_pipe.sv
// Pipelined signed x unsigned multiplier with valid/ready flow control.
// Stage 1 registers operands, stage 2 holds the raw product (DSP-friendly),
// middle stages delay the product, the last stage registers the clamped result.
// The whole pipe advances together whenever the output is empty or taken.
module kmerge_mul_pipe
   import kmerge_mul_pkg::*;
#(
   parameter int A_W       = 18,
   parameter int B_W       = 17,
   parameter int P_W       = 18,
   parameter int NUM_STAGE = 4,
   parameter int SAT_MODE  = SAT_MODE_WRAP
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [A_W-1:0]        din0,
   input  logic [B_W-1:0]        din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [P_W-1:0] dout,
   output logic                  ovf,
   output logic [3:0]            inflight
);

   localparam int FULL_W = A_W + B_W + 1;
   localparam int STAGES = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                           (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;

   logic                     advance_s;
   logic                     accept_s;
   logic                     deliver_s;
   logic [STAGES-1:0]        vld_q;
   logic [A_W-1:0]           a_q;
   logic [B_W-1:0]           b_q;
   logic signed [FULL_W-1:0] a_ext_s;
   logic signed [FULL_W-1:0] b_ext_s;
   logic signed [FULL_W-1:0] mult_s;
   logic signed [FULL_W-1:0] sat_in_s;
   logic signed [P_W-1:0]    sat_dout_s;
   logic                     sat_ovf_s;
   logic signed [P_W-1:0]    dout_q;
   logic                     ovf_q;
   logic [3:0]               inflight_q;
   logic [3:0]               inflight_d;

   assign advance_s = ~vld_q[STAGES-1] | out_ready;
   assign accept_s  = in_valid & advance_s;
   assign deliver_s = vld_q[STAGES-1] & out_ready;

   assign in_ready  = advance_s;
   assign out_valid = vld_q[STAGES-1];
   assign dout      = dout_q;
   assign ovf       = ovf_q;
   assign inflight  = inflight_q;

   // Valid bits shift with the data; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else if (advance_s) begin
         vld_q <= {vld_q[STAGES-2:0], in_valid};
      end
   end

   // Stage 1: operand registers (DSP input registers, no reset needed).
   always_ff @(posedge clk) begin
      if (advance_s) begin
         a_q <= din0;
         b_q <= din1;
      end
   end

   // din0 is sign-extended, din1 zero-extended; FULL_W holds the exact product.
   assign a_ext_s = {{(FULL_W-A_W){a_q[A_W-1]}}, a_q};
   assign b_ext_s = {{(FULL_W-B_W){1'b0}}, b_q};
   assign mult_s  = a_ext_s * b_ext_s;

   generate
      if (STAGES > 2) begin : g_prod
         logic signed [FULL_W-1:0] prod_q [STAGES-2];

         // Stage 2 captures the product; further stages are plain delay.
         always_ff @(posedge clk) begin
            if (advance_s) begin
               prod_q[0] <= mult_s;
               for (int i = 1; i < STAGES - 2; i++) begin
                  prod_q[i] <= prod_q[i-1];
               end
            end
         end

         assign sat_in_s = prod_q[STAGES-3];
      end else begin : g_noprod
         assign sat_in_s = mult_s;
      end
   endgenerate

   kmerge_mul_sat #(
      .FULL_W   (FULL_W),
      .P_W      (P_W),
      .SAT_MODE (SAT_MODE)
   ) u_sat (
      .prod_i (sat_in_s),
      .dout_o (sat_dout_s),
      .ovf_o  (sat_ovf_s)
   );

   // Output stage: registered result and overflow flag, held while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else if (advance_s) begin
         dout_q <= sat_dout_s;
         ovf_q  <= sat_ovf_s;
      end
   end

   // Occupancy: +1 on accept only, -1 on deliver only.
   always_comb begin
      inflight_d = inflight_q;
      case ({accept_s, deliver_s})
         2'b10:   inflight_d = inflight_q + 4'd1;
         2'b01:   inflight_d = inflight_q - 4'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q <= 4'd0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_kmerge_mul_pipe.sv
// Bench for kmerge_mul_pipe: a wrap-mode and a saturate-mode instance share
// stimulus; a queue-based reference model tracks every accepted pair.
module tb_kmerge_mul_pipe;

   localparam int A_W = 18;
   localparam int B_W = 17;
   localparam int P_W = 18;
   localparam int NS  = 4;
   localparam longint MAXV = (64'sd1 <<< (P_W-1)) - 64'sd1;
   localparam longint MINV = -(64'sd1 <<< (P_W-1));

   logic                  clk       = 1'b0;
   logic                  reset     = 1'b1;
   logic                  in_valid  = 1'b0;
   logic                  out_ready = 1'b1;
   logic [A_W-1:0]        din0      = '0;
   logic [B_W-1:0]        din1      = '0;

   logic                  in_ready_w, in_ready_s;
   logic                  out_valid_w, out_valid_s;
   logic signed [P_W-1:0] dout_w, dout_s;
   logic                  ovf_w, ovf_s;
   logic [3:0]            inflight_w, inflight_s;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   kmerge_mul_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .NUM_STAGE(NS), .SAT_MODE(0)) dut_w (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
      .din0(din0), .din1(din1), .out_valid(out_valid_w), .out_ready(out_ready),
      .dout(dout_w), .ovf(ovf_w), .inflight(inflight_w));

   kmerge_mul_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .NUM_STAGE(NS), .SAT_MODE(1)) dut_s (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
      .din0(din0), .din1(din1), .out_valid(out_valid_s), .out_ready(out_ready),
      .dout(dout_s), .ovf(ovf_s), .inflight(inflight_s));

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the product / range rules.
   task automatic ref_calc(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                           output longint w, output bit o, output longint s);
      longint p;
      longint m;
      p = longint'($signed(a)) * longint'({1'b0, b});
      o = (p > MAXV) || (p < MINV);
      m = p & ((64'sd1 <<< P_W) - 64'sd1);
      if (m > MAXV) m = m - (64'sd1 <<< P_W);
      w = m;
      s = o ? ((p > 0) ? MAXV : MINV) : p;
   endtask

   // Scoreboard: each accepted pair advances one stage per advancing cycle.
   typedef struct {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      int             stage;
   } item_t;
   item_t  q[$];
   longint dlog[$];

   always @(negedge clk) begin
      bit     exp_ov;
      bit     adv;
      longint ew, es;
      bit     eo;
      if (reset) begin
         q.delete();
      end else begin
         exp_ov = (q.size() > 0) && (q[0].stage == NS);
         adv    = !exp_ov || out_ready;
         check("out_valid", 64'({out_valid_w, out_valid_s}), 64'({exp_ov, exp_ov}));
         check("in_ready", 64'({in_ready_w, in_ready_s}), 64'({adv, adv}));
         check("inflight", 64'(inflight_w), 64'(q.size()));
         check("inflight_sat", 64'(inflight_s), 64'(q.size()));
         if (exp_ov) begin
            ref_calc(q[0].a, q[0].b, ew, eo, es);
            check("dout_wrap", 64'($signed(dout_w)), ew);
            check("ovf_wrap", 64'(ovf_w), 64'(eo));
            check("dout_sat", 64'($signed(dout_s)), es);
            check("ovf_sat", 64'(ovf_s), 64'(eo));
            if (out_ready) begin
               dlog.push_back(64'($signed(dout_w)));
               void'(q.pop_front());
            end
         end
         if (adv) begin
            foreach (q[i]) q[i].stage++;
            if (in_valid) q.push_back('{a: din0, b: din1, stage: 1});
         end
      end
   end

   typedef struct {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      longint         w;
      bit             o;
      longint         s;
   } vec_t;
   vec_t tbl[$];

   task automatic add_vec(input int a, input int b, input longint w, input bit o,
                          input longint s);
      vec_t v;
      v.a = A_W'(a);
      v.b = B_W'(b);
      v.w = w;
      v.o = o;
      v.s = s;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  idx;
      bit  acc;
      int  peak;
      bit  iv[14];

      add_vec(-3,      5,      -15,     1'b0, -15);
      add_vec(131071,  131071, 1,       1'b1, 131071);
      add_vec(-131072, 2,      0,       1'b1, -131072);
      add_vec(0,       131071, 0,       1'b0, 0);
      add_vec(131071,  1,      131071,  1'b0, 131071);
      add_vec(-131072, 1,      -131072, 1'b0, -131072);
      add_vec(65536,   2,      -131072, 1'b1, 131071);
      add_vec(-1,      131071, -131071, 1'b0, -131071);
      add_vec(-65537,  2,      131070,  1'b1, -131072);
      add_vec(7,       9,      63,      1'b0, 63);

      repeat (3) tick();
      check("reset_dout", 64'($signed(dout_w)), 64'sd0);
      check("reset_ovf", 64'(ovf_w), 64'sd0);
      reset = 1'b0;

      // Directed vectors: single pair, fixed 4-cycle latency, exact result.
      out_ready = 1'b1;
      foreach (tbl[i]) begin
         in_valid = 1'b1;
         din0 = tbl[i].a;
         din1 = tbl[i].b;
         for (int k = 1; k <= NS; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
            check("latency_out_valid", 64'(out_valid_w), 64'(k == NS));
         end
         check("tbl_dout_wrap", 64'($signed(dout_w)), tbl[i].w);
         check("tbl_ovf", 64'(ovf_w), 64'(tbl[i].o));
         check("tbl_dout_sat", 64'($signed(dout_s)), tbl[i].s);
         check("tbl_ovf_sat", 64'(ovf_s), 64'(tbl[i].o));
         tick();
      end

      // Back-to-back 1..6 times 3 with a 3-cycle consumer stall mid-stream.
      dlog.delete();
      idx  = 0;
      peak = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid  = (idx < 6);
         din0      = A_W'(idx + 1);
         din1      = B_W'(3);
         out_ready = !(cyc >= 5 && cyc < 8);
         @(negedge clk);
         acc = in_valid && in_ready_w;
         if (int'(inflight_w) > peak) peak = int'(inflight_w);
         tick();
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stall_count", 64'(dlog.size()), 64'sd6);
      for (int k = 0; k < 6; k++) begin
         if (k < dlog.size()) check("stall_order", dlog[k], 64'(3 * (k + 1)));
      end
      check("stall_peak_inflight", 64'(peak), 64'(NS));

      // Reset with three operations in flight; in_valid high during reset.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         din0 = A_W'(100 + k);
         din1 = B_W'(7);
         tick();
      end
      check("pre_reset_inflight", 64'(inflight_w), 64'sd3);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("post_reset_out_valid", 64'(out_valid_w), 64'sd0);
      check("post_reset_inflight", 64'(inflight_w), 64'sd0);
      check("post_reset_dout", 64'($signed(dout_w)), 64'sd0);
      check("post_reset_ovf", 64'(ovf_w), 64'sd0);
      repeat (8) tick();

      // Alternating in_valid: out_valid mirrors it four cycles later.
      for (int m = 0; m < 14; m++) iv[m] = (m < 8) && (m % 2 == 0);
      for (int m = 0; m < 14; m++) begin
         check("alt_out_valid", 64'(out_valid_w), 64'((m >= NS) ? iv[m-NS] : 1'b0));
         in_valid = iv[m];
         din0 = A_W'(m);
         din1 = B_W'(m + 1);
         tick();
      end

      // Random traffic with random backpressure against the model.
      for (int c = 0; c < 400; c++) begin
         in_valid  = $urandom_range(0, 1) == 1;
         out_ready = $urandom_range(0, 9) < 7;
         din0      = A_W'($urandom);
         din1      = B_W'($urandom);
         case ($urandom_range(0, 7))
            0:       din0 = 18'h1FFFF;
            1:       din0 = 18'h20000;
            default: din0 = din0;
         endcase
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
      check("drain_empty", 64'(q.size()), 64'sd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/kmerge_mul_pipe.md
KMERGE_MUL_PIPE -- requirements
Module: kmerge_mul_pipe

Interface
REQ-001 SHALL have parameter A_W, default 18, signed multiplicand width.
REQ-002 SHALL have parameter B_W, default 17, unsigned multiplier width.
REQ-003 SHALL have parameter P_W, default 18, result width; legal range 2..A_W+B_W+1.
REQ-004 SHALL have parameter NUM_STAGE, default 4, input-to-output latency in cycles; legal range 2..8.
REQ-005 SHALL have parameter SAT_MODE, default 0; 0 = wrap (keep low P_W bits), 1 = saturate to the signed P_W range.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, din0/din1 are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1, block accepts an operand pair this cycle.
REQ-010 SHALL have port din0, input, A_W, signed operand.
REQ-011 SHALL have port din1, input, B_W, unsigned operand (zero-extended).
REQ-012 SHALL have port out_valid, output, 1, dout/ovf are valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port dout, output, P_W, signed result.
REQ-015 SHALL have port ovf, output, 1, the full product does not fit in signed P_W.
REQ-016 SHALL have port inflight, output, 4, count of accepted but not yet delivered operations.

Function
REQ-017 SHALL compute full product = din0 * signed({0,din1}) at width A_W+B_W+1 with no loss.
REQ-018 SHALL set dout = low P_W bits of the product in wrap mode, or the product clamped to [-2^(P_W-1), 2^(P_W-1)-1] in saturate mode.
REQ-019 SHALL set ovf = 1 whenever the full product lies outside the signed P_W range, in both modes.
REQ-020 SHALL define advance = !out_valid || out_ready and drive in_ready = advance.
REQ-021 SHALL accept a transfer when in_valid && in_ready, and deliver one when out_valid && out_ready.
REQ-022 SHALL shift every pipeline stage, data and valid bit alike, only on cycles where advance = 1; when advance = 0 all stages hold.
REQ-023 SHALL present an accepted pair on dout exactly NUM_STAGE cycles after acceptance when advance stays 1, with a throughput of one result per cycle.
REQ-024 SHALL propagate bubbles (advance with in_valid = 0) as valid = 0, with no spurious out_valid.
REQ-025 SHALL hold dout, ovf and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL deliver results in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-027 SHALL update inflight as +1 on acceptance only, -1 on delivery only, and unchanged on both or neither; inflight never exceeds NUM_STAGE.
REQ-028 SHALL keep in_ready purely combinational from out_valid and out_ready, and not dependent on in_valid.

Reset
REQ-029 SHALL, on reset = 1 at a clock edge, clear all stage valid bits, set out_valid = 0 and inflight = 0 next cycle, and discard in-flight data.
REQ-030 SHALL set dout = 0 and ovf = 0 at reset; data registers other than the output stage need not be reset.
REQ-031 SHALL ignore in_valid during the reset cycle.

Structure
REQ-032 SHALL place the SAT_MODE encodings (WRAP = 0, SAT = 1) and the NUM_STAGE legal limits in shared package kmerge_mul_pkg.
REQ-033 SHALL implement the range check, clamp and ovf generation in one combinational sub-module kmerge_mul_sat, instantiated once before the output stage.
REQ-034 SHALL register operand inputs in stage 1 and keep the multiply in a dedicated stage, so it maps onto a DSP with input and output registers.

Verification
REQ-035 SHALL pass this case: wrap, din0 = -3, din1 = 5, out_ready = 1 -> dout = -15, ovf = 0, out_valid exactly 4 cycles after acceptance.
REQ-036 SHALL pass this case: din0 = 131071, din1 = 131071 -> wrap gives dout = 1, ovf = 1; saturate gives dout = 131071, ovf = 1.
REQ-037 SHALL pass this case: din0 = -131072, din1 = 2 -> wrap gives dout = 0, ovf = 1; saturate gives dout = -131072, ovf = 1.
REQ-038 SHALL pass this case: 6 back-to-back inputs 1..6 times 3 with out_ready low for 3 cycles mid-stream -> outputs 3,6,9,12,15,18 in order, held stable while stalled, inflight peaking at 4.
REQ-039 SHALL pass this case: reset asserted with inflight = 3 -> next cycle out_valid = 0, inflight = 0, dout = 0, and no old result ever appears.
REQ-040 SHALL pass this case: alternating in_valid 1/0 -> out_valid alternates 1/0 after latency 4, with no extra outputs.
